// File: rtl/uart_tx_fc.sv
// UART transmitter (8N1, LSB first, idle high) with CTS flow control.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps

module uart_tx_fc #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       cts,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CTS,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              tx_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              baud_last;
  logic              accept;
  logic              in_frame;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign ready     = (state == IDLE);
  assign accept    = valid && ready;
  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign in_frame  = (state == START) || (state == DATA) || (state == STOP)
`ifdef UART_TX_PARITY_EN
                     || (state == PARITY)
`endif
                     ;

  // tx_next is derived from the current state and registered, so the line
  // lags the state by one cycle; that lag gives the two-cycle accept-to-start
  // latency and lets ready rise during the final stop-bit cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    tx_next    = 1'b1;
    case (state)
      IDLE:     if (accept) state_next = WAIT_CTS;
      WAIT_CTS: if (!cts) state_next = START;
      START: begin
        tx_next = 1'b0;
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_last && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_bit;
        if (baud_last) state_next = STOP;
      end
`endif
      STOP:     if (baud_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      // Covers the accept cycle and the extra cycle the registered stop bit outlives the state.
      busy  <= (state != IDLE) || (state_next != IDLE);

      if (in_frame) baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
      else          baud_cnt <= '0;

      if (state == DATA) begin
        if (baud_last) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= '0;
      end

      if (accept)                         shift <= data_in;
      else if (state == DATA && baud_last) shift <= {1'b0, shift[7:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       parity_bit <= 1'b0;
    else if (accept) parity_bit <= ^data_in;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fc.sv
// Self-checking bench for uart_tx_fc: each captured frame is compared cycle by cycle
// against a waveform built from the 8N1 (or 8E1 with UART_TX_PARITY_EN) frame rules.
`timescale 1ns/1ps

module tb_uart_tx_fc;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC   = FRAME_BITS * CPB;
  localparam int WAIT_BUDGET = 400;

  typedef logic [FRAME_CYC-1:0] wave_t;

  // Sample j of a frame is taken at the j-th negedge after tx first goes low.
  localparam wave_t RDY_EXP = {1'b1, {(FRAME_CYC-1){1'b0}}};
  localparam wave_t BSY_EXP = {FRAME_CYC{1'b1}};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       cts;
  logic       tx;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_fc #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .cts     (cts),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference frame: list of bit cells, each stretched to CPB cycles.
  function automatic wave_t model_wave(input logic [7:0] d);
    bit    cells[$];
    wave_t w;
    cells.push_back(1'b0);
    for (int i = 0; i < 8; i++) cells.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    cells.push_back(^d);
`endif
    cells.push_back(1'b1);
    for (int j = 0; j < FRAME_CYC; j++) w[j] = cells[j / CPB];
    return w;
  endfunction

  // Holds valid until the handshake edge; returns just after that edge.
  task automatic send_byte(input logic [7:0] d, output bit ok);
    data_in = d;
    valid   = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
  endtask

  // delay = negedges seen before the first low tx sample.
  task automatic capture(output wave_t w, output wave_t rdy, output wave_t bsy,
                         output int delay, output bit ok);
    delay = 0;
    ok    = 1'b0;
    w     = '0;
    rdy   = '0;
    bsy   = '0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      delay++;
    end
    if (ok) begin
      w[0] = tx; rdy[0] = ready; bsy[0] = busy;
      for (int j = 1; j < FRAME_CYC; j++) begin
        @(negedge clk);
        w[j] = tx; rdy[j] = ready; bsy[j] = busy;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; valid = 1'b0; cts = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 cts = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL idle_after_reset: %0d bad cycles of 20, expected 0", bad);
    end
    cts = 1'b0;
  endtask

  task automatic test_basic();
    wave_t w, rdy, bsy;
    int    delay;
    bit    sent, found;
    cts = 1'b0;
    @(posedge clk); #1;
    send_byte(8'hA5, sent);
    capture(w, rdy, bsy, delay, found);
    compared++;
    if (!sent || !found || delay != 2) begin
      mismatched++;
      $display("FAIL a5_start_delay: sent=%b found=%b delay=%0d, expected 2", sent, found, delay);
    end
    compared++;
    if (w !== model_wave(8'hA5)) begin
      mismatched++;
      $display("FAIL a5_wave: got %h expected %h", w, model_wave(8'hA5));
    end
    compared++;
    if ({rdy, bsy} !== {RDY_EXP, BSY_EXP}) begin
      mismatched++;
      $display("FAIL a5_ready_busy: ready %h busy %h, expected %h %h", rdy, bsy, RDY_EXP, BSY_EXP);
    end
  endtask

  task automatic test_cts_hold();
    wave_t w, rdy, bsy;
    int    delay, bad;
    bit    sent, found;
    cts = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h3C, sent);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) bad++;
    end
    compared++;
    if (!sent || bad != 0) begin
      mismatched++;
      $display("FAIL cts_hold: sent=%b bad cycles=%0d, expected sent=1 and 0", sent, bad);
    end
    @(posedge clk); #1 cts = 1'b0;
    capture(w, rdy, bsy, delay, found);
    compared++;
    if (!found || delay != 2) begin
      mismatched++;
      $display("FAIL cts_release_delay: found=%b delay=%0d, expected 2", found, delay);
    end
    compared++;
    if (w !== model_wave(8'h3C)) begin
      mismatched++;
      $display("FAIL 3c_wave: got %h expected %h", w, model_wave(8'h3C));
    end
  endtask

  task automatic test_back_to_back();
    wave_t w, rdy, bsy;
    int    delay;
    bit    sent, found;
    cts = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h55, sent);
    data_in = 8'hFF;
    valid   = 1'b1;
    capture(w, rdy, bsy, delay, found);
    compared++;
    if (!sent || !found || delay != 2 || w !== model_wave(8'h55)) begin
      mismatched++;
      $display("FAIL b2b_first: delay=%0d wave %h, expected 2 and %h", delay, w, model_wave(8'h55));
    end
    compared++;
    if ({rdy, bsy} !== {RDY_EXP, BSY_EXP}) begin
      mismatched++;
      $display("FAIL b2b_first_ready_busy: ready %h busy %h, expected %h %h", rdy, bsy, RDY_EXP, BSY_EXP);
    end
    @(posedge clk); #1 valid = 1'b0;
    capture(w, rdy, bsy, delay, found);
    compared++;
    if (!found || delay != 2) begin
      mismatched++;
      $display("FAIL b2b_gap: found=%b delay=%0d, expected 2", found, delay);
    end
    compared++;
    if (w !== model_wave(8'hFF)) begin
      mismatched++;
      $display("FAIL b2b_second_wave: got %h expected %h", w, model_wave(8'hFF));
    end
  endtask

  task automatic test_cts_midframe();
    wave_t w, rdy, bsy;
    int    delay, bad;
    bit    sent, found;
    cts = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h81, sent);
    fork
      capture(w, rdy, bsy, delay, found);
      begin
        // Lands inside data bit 3 on the line.
        repeat (19) @(posedge clk);
        #1 cts = 1'b1;
      end
    join
    compared++;
    if (!sent || !found || delay != 2 || w !== model_wave(8'h81)) begin
      mismatched++;
      $display("FAIL cts_midframe_81: delay=%0d wave %h, expected 2 and %h", delay, w, model_wave(8'h81));
    end
    @(posedge clk); #1;
    send_byte(8'h42, sent);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) bad++;
    end
    compared++;
    if (!sent || bad != 0) begin
      mismatched++;
      $display("FAIL cts_midframe_next_waits: sent=%b bad cycles=%0d, expected sent=1 and 0", sent, bad);
    end
    @(posedge clk); #1 cts = 1'b0;
    capture(w, rdy, bsy, delay, found);
    compared++;
    if (!found || delay != 2 || w !== model_wave(8'h42)) begin
      mismatched++;
      $display("FAIL cts_midframe_42: delay=%0d wave %h, expected 2 and %h", delay, w, model_wave(8'h42));
    end
  endtask

  task automatic test_reset_midframe();
    wave_t w, rdy, bsy;
    int    delay;
    bit    sent, found;
    cts = 1'b0;
    @(posedge clk); #1;
    send_byte(8'hDF, sent);
    // 0xDF has bit 5 clear, so the line is low during that bit.
    repeat (27) @(posedge clk);
    #1;
    compared++;
    if (!sent || tx !== 1'b0) begin
      mismatched++;
      $display("FAIL bit5_low: sent=%b tx=%b, expected tx=0", sent, tx);
    end
    #1 reset = 1'b1;
    #1;
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: tx=%b busy=%b, expected tx=1 busy=0 before any edge", tx, busy);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    compared++;
    if (ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      mismatched++;
      $display("FAIL after_reset_release: ready=%b busy=%b tx=%b, expected 1 0 1", ready, busy, tx);
    end
    @(posedge clk); #1;
    send_byte(8'h00, sent);
    capture(w, rdy, bsy, delay, found);
    compared++;
    if (!sent || !found || delay != 2 || w !== model_wave(8'h00)) begin
      mismatched++;
      $display("FAIL post_reset_00: delay=%0d wave %h, expected 2 and %h", delay, w, model_wave(8'h00));
    end
  endtask

  task automatic test_random();
    wave_t       w, rdy, bsy;
    int          delay, hold, gap;
    bit          sent, found;
    logic [7:0]  d;
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom);
      hold = int'($urandom_range(0, 5));
      gap  = int'($urandom_range(0, 3));
      cts  = 1'b1;
      repeat (gap) @(posedge clk);
      @(posedge clk); #1;
      send_byte(d, sent);
      fork
        capture(w, rdy, bsy, delay, found);
        begin
          repeat (hold) @(posedge clk);
          #1 cts = 1'b0;
        end
      join
      compared++;
      if (!sent || !found || delay != hold + 2) begin
        mismatched++;
        $display("FAIL rand%0d_delay: delay=%0d expected %0d", n, delay, hold + 2);
      end
      compared++;
      if (w !== model_wave(d)) begin
        mismatched++;
        $display("FAIL rand%0d_wave: byte %h got %h expected %h", n, d, w, model_wave(d));
      end
      compared++;
      if ({rdy, bsy} !== {RDY_EXP, BSY_EXP}) begin
        mismatched++;
        $display("FAIL rand%0d_ready_busy: ready %h busy %h, expected %h %h", n, rdy, bsy, RDY_EXP, BSY_EXP);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    wave_t      w, rdy, bsy;
    int         delay;
    bit         sent, found;
    logic [7:0] bytes [2] = '{8'h07, 8'h03};
    logic       pexp  [2] = '{1'b1, 1'b0};
    cts = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      send_byte(bytes[n], sent);
      capture(w, rdy, bsy, delay, found);
      compared++;
      if (!sent || !found || w[9*CPB + 2] !== pexp[n]) begin
        mismatched++;
        $display("FAIL parity_%h: bit %b expected %b", bytes[n], w[9*CPB + 2], pexp[n]);
      end
      compared++;
      if (w !== model_wave(bytes[n]) || rdy !== RDY_EXP) begin
        mismatched++;
        $display("FAIL parity_frame_%h: wave %h ready %h expected %h %h",
                 bytes[n], w, rdy, model_wave(bytes[n]), RDY_EXP);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_cts_hold();
    test_back_to_back();
    test_cts_midframe();
    test_reset_midframe();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
